// File: rtl/ps2_device_tx_if.sv
// Signal bundle between the bench harness (master) and the PS/2 device-side
// transmitter (slave): scancode push, host inhibit, and the two PS/2 lines.
interface ps2_device_tx_if;
  logic       send;
  logic [7:0] scan_code;
  logic       host_inhibit;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       busy;
  logic       done;
  logic       fifo_full;
  logic       overflow;

  modport master (
    output send,
    output scan_code,
    output host_inhibit,
    input  ps2_clk,
    input  ps2_dat,
    input  busy,
    input  done,
    input  fifo_full,
    input  overflow
  );

  modport slave (
    input  send,
    input  scan_code,
    input  host_inhibit,
    output ps2_clk,
    output ps2_dat,
    output busy,
    output done,
    output fifo_full,
    output overflow
  );
endinterface

// File: rtl/ps2_device_tx.sv
// Keyboard-side PS/2 transmitter: queues scancodes in a small FIFO and sends each
// as an 11-bit device-to-host frame (start, 8 data LSB first, odd parity, stop).
module ps2_device_tx #(
  parameter int CLK_HALF   = 4,
  parameter int GAP_CYCLES = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            Clock,
  input  logic            Resetn,
  ps2_device_tx_if.slave  bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = 16;

  localparam logic [CW-1:0] H_LAST   = CW'(CLK_HALF - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(FIFO_DEPTH - 1);
  localparam logic [3:0]    LAST_BIT = 4'd10;
  localparam logic [3:0]    INH_BIT  = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_LOW     = 3'd2,
    S_GAP     = 3'd3,
    S_INHIBIT = 3'd4
  } state_e;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  function automatic logic [10:0] build_frame(input logic [7:0] data);
    return {1'b1, odd_parity(data), data, 1'b0};
  endfunction

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] ptr);
    logic [AW-1:0] nxt;
    if (ptr == PTR_LAST) begin
      nxt = '0;
    end else begin
      nxt = ptr + AW'(1);
    end
    return nxt;
  endfunction

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [10:0]   frame_q, frame_d;

  logic          ps2_clk_q, ps2_clk_d;
  logic          ps2_dat_q, ps2_dat_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;

  logic          pop_s;
  logic          push_ok_s;
  logic          full_s;
  logic          inhibit_hit_s;

  // Transmit sequencer: bit timing, inhibit abort and the frame-complete pop.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    frame_d       = frame_q;
    pop_s         = 1'b0;
    done_d        = 1'b0;
    inhibit_hit_s = bus.host_inhibit && (bit_q <= INH_BIT);

    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && !bus.host_inhibit) begin
          state_d = S_SETUP;
          frame_d = build_frame(mem_q[rd_ptr_q]);
          bit_d   = 4'd0;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (inhibit_hit_s) begin
          state_d = S_INHIBIT;
          cnt_d   = '0;
        end else if (cnt_q == H_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_LOW: begin
        if (inhibit_hit_s) begin
          state_d = S_INHIBIT;
          cnt_d   = '0;
        end else if (cnt_q == H_LAST) begin
          cnt_d = '0;
          if (bit_q == LAST_BIT) begin
            // Byte leaves the FIFO only once its stop bit has fully gone out.
            pop_s   = 1'b1;
            done_d  = 1'b1;
            state_d = S_GAP;
          end else begin
            bit_d   = bit_q + 4'd1;
            state_d = S_SETUP;
          end
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_INHIBIT: begin
        if (!bus.host_inhibit) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          state_d = S_INHIBIT;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = 4'd0;
      end
    endcase

    // Lines are derived from the next state so they change on the same edge.
    case (state_d)
      S_SETUP: begin
        ps2_clk_d = 1'b1;
        ps2_dat_d = frame_d[bit_d];
      end
      S_LOW: begin
        ps2_clk_d = 1'b0;
        ps2_dat_d = frame_d[bit_d];
      end
      default: begin
        ps2_clk_d = 1'b1;
        ps2_dat_d = 1'b1;
      end
    endcase
  end

  // FIFO bookkeeping; a push into a full FIFO survives only alongside a pop.
  always_comb begin
    full_s    = (count_q == DEPTH_C);
    push_ok_s = bus.send && (!full_s || pop_s);
    ovf_d     = bus.send && full_s && !pop_s;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    if (push_ok_s) begin
      wr_ptr_d = ptr_next(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push_ok_s && !pop_s) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (pop_s && !push_ok_s) begin
      count_d = count_q - (AW + 1)'(1);
    end else begin
      count_d = count_q;
    end

    full_d = (count_d == DEPTH_C);
    busy_d = (count_d != '0) || (state_d != S_IDLE);
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge Clock) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= bus.scan_code;
    end
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= 4'd0;
      frame_q   <= '1;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ps2_clk_q <= 1'b1;
      ps2_dat_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ps2_clk_q <= ps2_clk_d;
      ps2_dat_q <= ps2_dat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.ps2_clk   = ps2_clk_q;
  assign bus.ps2_dat   = ps2_dat_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fifo_full = full_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: doc/ps2_device_tx.md
# ps2_device_tx

Keyboard-side PS/2 device model for the Verilator bench that serialises scancodes onto ps2_clk/ps2_dat as genuine device-to-host frames. Scancodes arrive from the C++ harness on a push strobe. They are queued in a small FIFO and then clocked out with start, data, odd-parity and stop bits. This lets the real ps2Driver receive path run unmodified.

## Interface
- CLK_HALF, default 4: system cycles per PS/2 clock half-period (H); legal range 2..255.
- GAP_CYCLES, default 8: idle cycles with both lines high after each frame, and before a retry.
- FIFO_DEPTH, default 4: scancode queue depth; must be a power of two.
- Clock  in  1  system clock; all logic on its rising edge.
- Resetn  in  1  synchronous, active-low reset.
- send  in  1  push strobe; samples scan_code on each cycle it is high.
- scan_code  in  8  byte to transmit.
- host_inhibit  in  1  high models the host holding the clock low.
- ps2_clk  out  1  PS/2 clock, registered; 1 = released/high.
- ps2_dat  out  1  PS/2 data, registered; 1 = released/high.
- busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE.
- done  out  1  one-cycle pulse per completed frame.
- fifo_full  out  1  high when the FIFO count equals FIFO_DEPTH.
- overflow  out  1  one-cycle pulse when a push is dropped.

## Operation
- Reset values: ps2_clk=1, ps2_dat=1, busy=0, done=0, fifo_full=0, overflow=0. FIFO is emptied, state=IDLE, bit index=0.
- FIFO behaviour:
  - A push is accepted when not full, or when full and a pop occurs in the same cycle (count unchanged).
  - A push when full with no pop is dropped and pulses overflow.
  - Order is first-in, first-out.
- Frame format, bit index 0..10: start=0, data[0..7] LSB first, parity = ~^data (odd), stop=1.
- IDLE: both lines high. When the FIFO is non-empty and host_inhibit=0, load the FIFO head into the shift register (no pop yet), set bit index 0, go to SETUP.
- SETUP: ps2_dat = current frame bit, ps2_clk=1, held for H cycles, then go to LOW.
- LOW: ps2_clk=0 while ps2_dat is held, for H cycles. On completion:
  - if bit index < 10: increment the index and go to SETUP;
  - if bit index = 10: pop the FIFO, pulse done, go to GAP.
- GAP: both lines high for GAP_CYCLES cycles, then go to IDLE.
- Host inhibit:
  - host_inhibit=1 sampled in SETUP or LOW with bit index ≤ 9 → go to INHIBIT. Both lines are released (1) next cycle. The byte stays at the FIFO head.
  - If bit index = 10, inhibit is ignored and the frame completes.
- INHIBIT: lines stay high until host_inhibit=0, then go to GAP and retransmit the whole frame from the start bit.
- host_inhibit=1 in IDLE blocks a frame from starting. In GAP it has no effect.

## Timing
- Latency: send high in cycle 0 with the FIFO empty and the FSM in IDLE → ps2_dat=0 first visible in cycle 2.
- Each bit lasts 2H cycles: H with the clock high, then H with the clock low. Data is stable throughout both halves and changes only while ps2_clk=1, at least H cycles before the falling edge.
- Frame duration is 22H cycles from the start of SETUP for bit 0 to the end of LOW for bit 10.
- done is high for exactly the first GAP cycle. ps2_clk returns to 1 in that same cycle.
- Back-to-back frames: start-to-start spacing is 22H + GAP_CYCLES + 1 cycles (the extra cycle is the IDLE cycle).
- busy deasserts in the cycle after GAP ends if the FIFO is empty.
- fifo_full and overflow update in the cycle after the push edge.
- Reset mid-frame: lines are 1 in the cycle after Resetn is sampled low. No done pulse. Queued bytes are discarded.

## Test plan
- H=4, GAP=8: push 0x1C once.
  - Expect 11 ps2_clk falling edges.
  - Bits sampled at the falling edges: 0,0,0,1,1,1,0,0,0,0,1.
  - done pulses exactly once, 88 cycles after the start bit appears.
- Push 0xF0 and 0x1C on consecutive cycles.
  - Expect two frames in order; the second frame's parity bit is 0.
  - Start-bit edges 97 cycles apart.
  - busy stays high throughout.
- Push 0x00, then 0xFF.
  - Both frames carry parity bit 1; data is all-0 and all-1 respectively.
- With the FSM busy, push 6 bytes while the first frame is in flight (FIFO_DEPTH=4).
  - fifo_full asserts.
  - Exactly the pushes arriving while full produce overflow pulses.
  - The surviving bytes are transmitted in order.
- Assert host_inhibit during bit 5 LOW for 20 cycles.
  - Lines go high next cycle; no done pulse.
  - After release plus GAP, the full frame for the same byte is retransmitted.
- Assert host_inhibit during bit 10: frame completes normally. Pull Resetn low mid-frame: lines high next cycle, busy=0, FIFO empty.
